// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU-to-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_WAIT = 3'd2,
    D_REQ  = 3'd3,
    D_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates CPU instruction fetches and data loads/stores onto one memory port.
// Data accesses win over fetches; each transaction is latched on acceptance.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              imemRead,
  input  logic [WORD_W-1:0] imemAddr,
  input  logic              dmmRead,
  input  logic              dmmWrite,
  input  logic [WORD_W-1:0] dmmAddr,
  input  logic [WORD_W-1:0] dmmStore,
  output logic              i_ready,
  output logic [WORD_W-1:0] instr,
  output logic              d_ready,
  output logic [WORD_W-1:0] dmmLoad,
  input  logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_store,
  input  logic [WORD_W-1:0] mem_load
);

  state_t            r_state;
  state_t            w_next;
  logic              r_is_write;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_i_ready;
  logic              r_d_ready;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_load;

  logic w_data_req;
  logic w_accept;
  logic w_issue_rd;
  logic w_issue_wr;
  logic w_i_done;
  logic w_d_done;

  // A data request with both strobes set is a store; a fetch only wins when no data request is present.
  assign w_data_req = dmmRead | dmmWrite;
  assign w_accept   = (r_state == IDLE) & (w_data_req | imemRead);
  assign w_issue_wr = w_accept & dmmWrite;
  assign w_issue_rd = w_accept & ~dmmWrite;
  assign w_i_done   = (r_state == I_WAIT) & ~busy;
  assign w_d_done   = (r_state == D_WAIT) & ~busy;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_data_req)    w_next = D_REQ;
        else if (imemRead) w_next = I_REQ;
      end
      I_REQ:   w_next = I_WAIT;
      D_REQ:   w_next = D_WAIT;
      I_WAIT:  if (!busy) w_next = DONE;
      D_WAIT:  if (!busy) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_store     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_instr     <= '0;
      r_load      <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_read  <= w_issue_rd;
      r_mem_write <= w_issue_wr;
      r_i_ready   <= w_i_done;
      r_d_ready   <= w_d_done;
      if (w_accept) begin
        r_is_write <= w_data_req & dmmWrite;
        r_addr     <= w_data_req ? dmmAddr : imemAddr;
        r_store    <= dmmStore;
      end
      if (w_i_done)                r_instr <= mem_load;
      if (w_d_done && !r_is_write) r_load  <= mem_load;
    end
  end

  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign instr     = r_instr;
  assign dmmLoad   = r_load;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_store = r_store;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed reset/fetch checks, then randomized
// transactions with a memory responder and a completion monitor.
module tb_mem_arbiter;

  logic        clk;
  logic        nrst;
  logic        imemRead;
  logic [31:0] imemAddr;
  logic        dmmRead;
  logic        dmmWrite;
  logic [31:0] dmmAddr;
  logic [31:0] dmmStore;
  logic        i_ready;
  logic [31:0] instr;
  logic        d_ready;
  logic [31:0] dmmLoad;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic [31:0] mem_load;

  mem_arbiter dut (
    .clk(clk), .nrst(nrst),
    .imemRead(imemRead), .imemAddr(imemAddr),
    .dmmRead(dmmRead), .dmmWrite(dmmWrite), .dmmAddr(dmmAddr), .dmmStore(dmmStore),
    .i_ready(i_ready), .instr(instr), .d_ready(d_ready), .dmmLoad(dmmLoad),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_load(mem_load)
  );

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    int          nbusy;
  } mem_op_t;

  typedef struct {
    logic        is_instr;
    logic [31:0] exp_instr;
    logic [31:0] exp_load;
    int          nbusy;
  } resp_t;

  mem_op_t mem_q[$];
  resp_t   resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int ready_cnt = 0;
  int last_strobe_cyc = 0;
  logic [31:0] model_instr;
  logic [31:0] model_load;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_outputs_zero(input string tag);
    chk({tag, "_i_ready"}, 32'(i_ready), 32'd0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_store"}, mem_store, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_dmmLoad"}, dmmLoad, 32'd0);
  endfunction

  // Memory side: checks each request strobe against the expected order, then stalls and answers.
  task automatic responder();
    mem_op_t m;
    forever begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, mem_write, mem_read}, 32'd0);
        end else begin
          m = mem_q.pop_front();
          chk("strobe_write", 32'(mem_write), 32'(m.is_write));
          chk("strobe_read", 32'(mem_read), 32'(!m.is_write));
          chk("req_addr", mem_addr, m.addr);
          if (m.is_write) chk("req_store", mem_store, m.store);
          strobe_cnt++;
          last_strobe_cyc = cyc;
          busy     = (m.nbusy > 0);
          mem_load = (m.nbusy > 0) ? $urandom : m.load;
          @(posedge clk); #1;
          chk("strobe_one_cycle", {30'd0, mem_write, mem_read}, 32'd0);
          chk("wait_addr_held", mem_addr, m.addr);
          for (int i = 0; i < m.nbusy; i++) begin
            @(posedge clk); #1;
            chk("stall_addr_held", mem_addr, m.addr);
            if (i == m.nbusy - 1) begin
              busy     = 1'b0;
              mem_load = m.load;
            end else begin
              mem_load = $urandom;
            end
          end
        end
      end else begin
        busy     = 1'($urandom);
        mem_load = $urandom;
      end
    end
  endtask

  // Completion monitor: every ready pulse must match the next expected response.
  task automatic monitor();
    resp_t e;
    forever begin
      @(posedge clk); #1;
      if (i_ready || d_ready) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_ready", {30'd0, d_ready, i_ready}, 32'd0);
        end else begin
          e = resp_q.pop_front();
          chk("i_ready", 32'(i_ready), 32'(e.is_instr));
          chk("d_ready", 32'(d_ready), 32'(!e.is_instr));
          chk("instr", instr, e.exp_instr);
          chk("dmmLoad", dmmLoad, e.exp_load);
          chk("latency", 32'(cyc - last_strobe_cyc), 32'(e.nbusy + 2));
        end
        ready_cnt++;
      end
    end
  endtask

  task automatic push_op(input logic is_fetch, input logic is_write, input logic [31:0] addr,
                         input logic [31:0] store);
    mem_op_t m;
    resp_t   r;
    m.is_write = is_write;
    m.addr     = addr;
    m.store    = store;
    m.load     = $urandom;
    m.nbusy    = int'($urandom_range(0, 5));
    if (is_fetch) model_instr = m.load;
    else if (!is_write) model_load = m.load;
    r.is_instr  = is_fetch;
    r.exp_instr = model_instr;
    r.exp_load  = model_load;
    r.nbusy     = m.nbusy;
    mem_q.push_back(m);
    resp_q.push_back(r);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int kind;
    int nops;
    int start_strobe;
    int target;
    int w;
    logic [31:0] a_i;
    logic [31:0] a_d;
    logic [31:0] s_d;

    nrst = 1'b0; imemRead = 1'b0; imemAddr = '0; dmmRead = 1'b0; dmmWrite = 1'b0;
    dmmAddr = '0; dmmStore = '0; busy = 1'b0; mem_load = '0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");

    // Directed fetch with no stall.
    nrst = 1'b1;
    imemRead = 1'b1; imemAddr = 32'h0000_0004; mem_load = 32'h3E80_0093;
    @(posedge clk); #1;
    chk("fetch_mem_read", 32'(mem_read), 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h4);
    @(posedge clk); #1;
    chk("fetch_strobe_drop", 32'(mem_read), 32'd0);
    chk("fetch_no_early_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    chk("fetch_i_ready", 32'(i_ready), 32'd1);
    chk("fetch_instr", instr, 32'h3E80_0093);
    @(negedge clk); imemRead = 1'b0;
    @(posedge clk); #1;
    chk("fetch_ready_pulse", 32'(i_ready), 32'd0);

    // Reset in the middle of a stalled load.
    @(negedge clk); dmmRead = 1'b1; dmmAddr = 32'h100; busy = 1'b1;
    @(posedge clk); #1;
    chk("load_mem_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    chk("load_wait_addr", mem_addr, 32'h100);
    #2 nrst = 1'b0;
    #1 chk_outputs_zero("midreset");
    dmmRead = 1'b0;
    @(negedge clk);
    nrst = 1'b1; imemRead = 1'b1; imemAddr = 32'h8; busy = 1'b0; mem_load = 32'h1234_5678;
    @(posedge clk); #1;
    chk("post_reset_accept", 32'(mem_read), 32'd1);
    chk("post_reset_addr", mem_addr, 32'h8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_reset_i_ready", 32'(i_ready), 32'd1);
    chk("post_reset_instr", instr, 32'h1234_5678);
    @(negedge clk); imemRead = 1'b0;
    model_instr = 32'h1234_5678;
    model_load  = 32'h0;

    fork
      responder();
      monitor();
    join_none

    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kind = int'($urandom_range(0, 4));
      a_i = $urandom; a_d = $urandom; s_d = $urandom;
      start_strobe = strobe_cnt;
      case (kind)
        0: begin push_op(1'b1, 1'b0, a_i, s_d); nops = 1; imemRead = 1'b1; end
        1: begin push_op(1'b0, 1'b0, a_d, s_d); nops = 1; dmmRead = 1'b1; end
        2: begin push_op(1'b0, 1'b1, a_d, s_d); nops = 1; dmmWrite = 1'b1; end
        3: begin push_op(1'b0, 1'b1, a_d, s_d); nops = 1; dmmRead = 1'b1; dmmWrite = 1'b1; end
        default: begin
          push_op(1'b0, 1'b0, a_d, s_d);
          push_op(1'b1, 1'b0, a_i, s_d);
          nops = 2; dmmRead = 1'b1; imemRead = 1'b1;
        end
      endcase
      imemAddr = a_i; dmmAddr = a_d; dmmStore = s_d;
      target = ready_cnt + nops;
      w = 0;
      while (ready_cnt < target && w < 200) begin
        @(negedge clk);
        w++;
        if (i_ready) imemRead = 1'b0;
        if (d_ready) begin dmmRead = 1'b0; dmmWrite = 1'b0; end
        if (strobe_cnt > start_strobe) begin dmmAddr = $urandom; dmmStore = $urandom; end
        if (strobe_cnt >= start_strobe + nops) imemAddr = $urandom;
      end
      if (w >= 200) chk("txn_timeout", 32'(ready_cnt), 32'(target));
      imemRead = 1'b0; dmmRead = 1'b0; dmmWrite = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all data/address widths are fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset is asynchronous and active-low.
REQ-004 imemRead  input  1  CPU instruction-fetch request; held until i_ready.
REQ-005 imemAddr  input  32  fetch address (PC).
REQ-006 dmmRead  input  1  CPU data-load request; held until d_ready.
REQ-007 dmmWrite  input  1  CPU data-store request; held until d_ready.
REQ-008 dmmAddr  input  32  data address.
REQ-009 dmmStore  input  32  store data.
REQ-010 i_ready  output  1  one-cycle pulse: instr valid, fetch complete.
REQ-011 instr  output  32  last fetched instruction; holds until next fetch completes.
REQ-012 d_ready  output  1  one-cycle pulse: data access complete.
REQ-013 dmmLoad  output  32  last loaded word; holds until next load completes.
REQ-014 busy  input  1  memory busy; low = memory idle or result available.
REQ-015 mem_read, mem_write  output  1 each  memory request strobes.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_store  output  32  memory write data.
REQ-018 mem_load  input  32  memory read data, valid when busy low in wait state.

Function
REQ-019 FSM states SHALL be IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT, DONE.
REQ-020 IDLE: (dmmRead|dmmWrite) -> D_REQ; else imemRead -> I_REQ; else stay. Data has priority over fetch when both are high.
REQ-021 On leaving IDLE the request type, address and store data SHALL be latched; later CPU input changes do not affect the transaction.
REQ-022 dmmRead and dmmWrite both high SHALL be treated as a write.
REQ-023 I_REQ/D_REQ: assert mem_read (or mem_write) for exactly one cycle with mem_addr/mem_store driven from the latches; next state is the matching WAIT.
REQ-024 WAIT states: mem_addr/mem_store held, strobes low; busy=1 -> stay; busy=0 -> DONE, and on that edge instr (I_WAIT) or dmmLoad (D_WAIT, read only) SHALL capture mem_load.
REQ-025 DONE: exactly one of i_ready/d_ready is high for this single cycle; requests are ignored; next state is IDLE.
REQ-026 Minimum latency from request seen in IDLE to ready pulse SHALL be 3 cycles (request edge, REQ, WAIT with busy=0, ready in DONE); each busy=1 cycle in WAIT adds one.
REQ-027 A store completion SHALL NOT modify dmmLoad.
REQ-028 No timeout; a permanently high busy stalls in WAIT indefinitely.

Reset
REQ-029 nrst low SHALL immediately force IDLE and clear i_ready, d_ready, mem_read, mem_write, mem_addr, mem_store, instr, dmmLoad and all latches to 0, including mid-transaction.
REQ-030 The first request is accepted on the first rising edge after nrst deasserts.

Structure
REQ-031 Package mem_arbiter_pkg SHALL hold the state enum type and the 32-bit word width constant.
REQ-032 Single module; no sub-module; outputs are registered or decoded from state only (no combinational path from busy/mem_load to outputs).

Verification
REQ-033 Reset: nrst=0 mid D_WAIT -> all outputs 0 within the same cycle; state IDLE after release.
REQ-034 Fetch: imemRead=1, imemAddr=0x0000_0004, busy=0, mem_load=0x3E80_0093 -> mem_read one cycle with mem_addr=0x4, i_ready pulse 3 cycles later, instr=0x3E80_0093.
REQ-035 Load with stall: dmmRead=1, dmmAddr=0x100, busy high 4 WAIT cycles, mem_load=0xDEAD_BEEF -> d_ready at cycle 7, dmmLoad=0xDEAD_BEEF.
REQ-036 Store: dmmWrite=1, dmmAddr=0x200, dmmStore=0x0000_03E8 -> mem_write one cycle, mem_store=0x3E8, d_ready pulse, dmmLoad unchanged.
REQ-037 Priority: imemRead and dmmRead raised same cycle -> data transaction first, then fetch; requests held through DONE are not re-issued early.
REQ-038 Input change after accept: dmmAddr changed 0x100->0x300 during D_WAIT -> mem_addr stays 0x100.
